// File: rtl/ticket_vend_ctrl.sv
// Ticket vending controller: fare calculation, coin collection, change/refund and dispensing.
// Optional inactivity timeout in COLLECT enabled by defining TICKET_TIMEOUT_EN.
module ticket_vend_ctrl #(
  parameter int unsigned W         = 8,
  parameter int unsigned NSTA      = 16,
  parameter int unsigned LOC_IDX   = 2,
  parameter int unsigned BASE_FARE = 10,
  parameter int unsigned HOP_FARE  = 5,
  parameter int unsigned QTY_W     = 2,
  parameter int unsigned TO_CYC    = 100
) (
  input  logic                    clkm,
  input  logic                    rstm,
  input  logic                    sel_valid,
  input  logic [$clog2(NSTA)-1:0] sel_station,
  input  logic [QTY_W-1:0]        sel_qty,
  input  logic                    coin_valid,
  input  logic [W-1:0]            coin_val,
  input  logic                    cancel,
  input  logic                    sensor_t,
  input  logic                    chg_ready,
  output logic                    chg_valid,
  output logic [W-1:0]            chg_amt,
  output logic                    tkt_pulse,
  output logic [$clog2(NSTA)-1:0] tkt_dest,
  output logic [W-1:0]            disp_val,
  output logic                    coin_rej,
  output logic                    err,
  output logic [3:0]              state
);

  localparam int unsigned SW = $clog2(NSTA);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StCalc     = 4'd1,
    StCollect  = 4'd2,
    StChange   = 4'd3,
    StDispense = 4'd4,
    StTake     = 4'd5,
    StRefund   = 4'd6,
    StClear    = 4'd7
  } state_e;

  state_e           st_q, st_d;
  logic [SW-1:0]    dest_q, dest_d;
  logic [QTY_W-1:0] left_q, left_d;
  logic [W-1:0]     fare_q, fare_d;
  logic [W-1:0]     paid_q, paid_d;
  logic             err_q, err_d;
  logic             rej_q, rej_d;

  logic [W:0]  coin_sum;
  logic        coin_ok;
  logic [31:0] hops;
  logic [31:0] fare_full;
  logic        to_hit;

  assign coin_sum = {1'b0, paid_q} + {1'b0, coin_val};
  assign coin_ok  = coin_valid && !coin_sum[W];

  always_comb begin
    hops = (32'(dest_q) >= LOC_IDX) ? (32'(dest_q) - LOC_IDX) : (LOC_IDX - 32'(dest_q));
    fare_full = (BASE_FARE + hops * HOP_FARE) * 32'(left_q);
  end

`ifdef TICKET_TIMEOUT_EN
  logic [31:0] to_q, to_d;

  // Restarts on COLLECT entry (cleared elsewhere) and on every accepted coin.
  always_comb begin
    to_d   = '0;
    to_hit = 1'b0;
    if (st_q == StCollect && !coin_ok) begin
      to_d   = to_q + 32'd1;
      to_hit = (to_d == TO_CYC);
    end
  end

  always_ff @(posedge clkm or posedge rstm) begin
    if (rstm) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    st_d   = st_q;
    dest_d = dest_q;
    left_d = left_q;
    fare_d = fare_q;
    paid_d = paid_q;
    err_d  = 1'b0;
    rej_d  = coin_valid && (st_q != StCollect);
    unique case (st_q)
      StIdle: begin
        if (sel_valid) begin
          if (32'(sel_station) >= NSTA || sel_qty == '0) begin
            err_d = 1'b1;
          end else begin
            dest_d = sel_station;
            left_d = sel_qty;
            st_d   = StCalc;
          end
        end
      end
      StCalc: begin
        if ((fare_full >> W) != 32'd0) begin
          err_d  = 1'b1;
          left_d = '0;
          st_d   = StIdle;
        end else begin
          fare_d = fare_full[W-1:0];
          paid_d = '0;
          st_d   = StCollect;
        end
      end
      StCollect: begin
        // Coin is folded in before cancel so a simultaneous coin is refunded too.
        if (coin_valid) begin
          if (coin_sum[W]) rej_d = 1'b1;
          else             paid_d = coin_sum[W-1:0];
        end
        if (cancel || to_hit) begin
          st_d = (paid_d != '0) ? StRefund : StClear;
        end else if (paid_d >= fare_q) begin
          st_d = (paid_d > fare_q) ? StChange : StDispense;
        end
      end
      StChange: begin
        if (chg_ready) st_d = StDispense;
      end
      StDispense: begin
        st_d = StTake;
      end
      StTake: begin
        if (sensor_t) begin
          left_d = left_q - QTY_W'(1);
          st_d   = (left_d != '0) ? StDispense : StClear;
        end
      end
      StRefund: begin
        if (chg_ready) st_d = StClear;
      end
      StClear: begin
        paid_d = '0;
        fare_d = '0;
        left_d = '0;
        st_d   = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clkm or posedge rstm) begin
    if (rstm) begin
      st_q   <= StIdle;
      dest_q <= '0;
      left_q <= '0;
      fare_q <= '0;
      paid_q <= '0;
      err_q  <= 1'b0;
      rej_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      dest_q <= dest_d;
      left_q <= left_d;
      fare_q <= fare_d;
      paid_q <= paid_d;
      err_q  <= err_d;
      rej_q  <= rej_d;
    end
  end

  // Handshake outputs decode straight from state so reset drops them at once.
  always_comb begin
    chg_valid = (st_q == StChange) || (st_q == StRefund);
    chg_amt   = '0;
    disp_val  = '0;
    if (st_q == StChange)      chg_amt = paid_q - fare_q;
    else if (st_q == StRefund) chg_amt = paid_q;
    if (st_q == StCollect)     disp_val = fare_q - paid_q;
    else if (chg_valid)        disp_val = chg_amt;
    tkt_pulse = (st_q == StDispense);
    tkt_dest  = tkt_pulse ? dest_q : '0;
  end

  assign coin_rej = rej_q;
  assign err      = err_q;
  assign state    = st_q;

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Self-checking bench for ticket_vend_ctrl: behavioural fare/payment model plus directed scenarios.
module tb_ticket_vend_ctrl;

  logic       clkm, rstm, rst2;
  logic       sel_valid, coin_valid, cancel, sensor_t, chg_ready;
  logic [3:0] sel_station;
  logic [1:0] sel_qty;
  logic [7:0] coin_val;
  logic       chg_valid, tkt_pulse, coin_rej, err;
  logic [7:0] chg_amt, disp_val;
  logic [3:0] tkt_dest, state;
  logic       s_chg_valid, s_tkt_pulse, s_coin_rej, s_err;
  logic [7:0] s_chg_amt, s_disp_val;
  logic [3:0] s_tkt_dest, s_state;

  int total = 0;
  int bad   = 0;

  ticket_vend_ctrl u_dut (
    .clkm(clkm), .rstm(rstm), .sel_valid(sel_valid), .sel_station(sel_station),
    .sel_qty(sel_qty), .coin_valid(coin_valid), .coin_val(coin_val), .cancel(cancel),
    .sensor_t(sensor_t), .chg_ready(chg_ready), .chg_valid(chg_valid), .chg_amt(chg_amt),
    .tkt_pulse(tkt_pulse), .tkt_dest(tkt_dest), .disp_val(disp_val), .coin_rej(coin_rej),
    .err(err), .state(state)
  );

  // Second instance: 12 stations and a steep hop fare to reach out-of-range and overflow errors.
  ticket_vend_ctrl #(.NSTA(12), .HOP_FARE(30)) u_small (
    .clkm(clkm), .rstm(rst2), .sel_valid(sel_valid), .sel_station(sel_station),
    .sel_qty(sel_qty), .coin_valid(coin_valid), .coin_val(coin_val), .cancel(cancel),
    .sensor_t(sensor_t), .chg_ready(chg_ready), .chg_valid(s_chg_valid), .chg_amt(s_chg_amt),
    .tkt_pulse(s_tkt_pulse), .tkt_dest(s_tkt_dest), .disp_val(s_disp_val),
    .coin_rej(s_coin_rej), .err(s_err), .state(s_state)
  );

  initial clkm = 1'b0;
  always #5 clkm = ~clkm;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d want=%0d", nm, $time, act, exp);
    end
  endfunction

  // Model: state codes as numbered in the spec, money as plain ints.
  int m_st, m_paid, m_fare, m_left, m_dest, m_to;
  bit m_err, m_rej;

  always @(posedge clkm or posedge rstm) begin : model
    int n_st, n_paid, n_fare, n_left, n_dest, n_to, hops, f, p;
    bit e, r, acc, quit;
    if (rstm) begin
      m_st <= 0; m_paid <= 0; m_fare <= 0; m_left <= 0; m_dest <= 0; m_to <= 0;
      m_err <= 0; m_rej <= 0;
    end else begin
      n_st = m_st; n_paid = m_paid; n_fare = m_fare; n_left = m_left; n_dest = m_dest;
      n_to = 0; e = 0; r = coin_valid && (m_st != 2);
      case (m_st)
        0: if (sel_valid) begin
          if (int'(sel_station) >= 16 || sel_qty == 0) e = 1;
          else begin n_dest = int'(sel_station); n_left = int'(sel_qty); n_st = 1; end
        end
        1: begin
          hops = (m_dest > 2) ? m_dest - 2 : 2 - m_dest;
          f = (10 + 5 * hops) * m_left;
          if (f > 255) begin e = 1; n_left = 0; n_st = 0; end
          else begin n_fare = f; n_paid = 0; n_st = 2; end
        end
        2: begin
          p = m_paid; acc = 0;
          if (coin_valid) begin
            if (p + int'(coin_val) > 255) r = 1;
            else begin p = p + int'(coin_val); acc = 1; end
          end
          n_to = acc ? 0 : m_to + 1;
          quit = cancel;
`ifdef TICKET_TIMEOUT_EN
          if (n_to == 100) quit = 1;
`endif
          if (quit) n_st = (p > 0) ? 6 : 7;
          else if (p >= m_fare) n_st = (p > m_fare) ? 3 : 4;
          n_paid = p;
        end
        3: if (chg_ready) n_st = 4;
        4: n_st = 5;
        5: if (sensor_t) begin n_left = m_left - 1; n_st = (n_left != 0) ? 4 : 7; end
        6: if (chg_ready) n_st = 7;
        default: begin n_paid = 0; n_fare = 0; n_left = 0; n_st = 0; end
      endcase
      m_st <= n_st; m_paid <= n_paid; m_fare <= n_fare; m_left <= n_left; m_dest <= n_dest;
      m_to <= n_to; m_err <= e; m_rej <= r;
    end
  end

  always @(negedge clkm) begin : compare
    int amt;
    amt = (m_st == 3) ? m_paid - m_fare : (m_st == 6) ? m_paid : 0;
    chk("state", int'(state), m_st);
    chk("chg_valid", int'(chg_valid), int'(m_st == 3 || m_st == 6));
    chk("chg_amt", int'(chg_amt), amt);
    chk("disp_val", int'(disp_val), (m_st == 2) ? m_fare - m_paid : amt);
    chk("tkt_pulse", int'(tkt_pulse), int'(m_st == 4));
    chk("tkt_dest", int'(tkt_dest), (m_st == 4) ? m_dest : 0);
    chk("err", int'(err), int'(m_err));
    chk("coin_rej", int'(coin_rej), int'(m_rej));
  end

  task automatic step();
    @(posedge clkm);
    #1;
    sel_valid = 0; coin_valid = 0; cancel = 0; sensor_t = 0; chg_ready = 0;
  endtask

  task automatic sel(input int st, input int q);
    sel_station = 4'(st); sel_qty = 2'(q); sel_valid = 1;
    step();
    step();
  endtask

  task automatic coin(input int v);
    coin_val = 8'(v); coin_valid = 1;
    step();
  endtask

  task automatic take_tickets(input int n, input int dest);
    for (int i = 0; i < n; i++) begin
      chk("lit_pulse", int'(tkt_pulse), 1);
      chk("lit_dest", int'(tkt_dest), dest);
      step();
      chk("lit_take", int'(state), 5);
      sensor_t = 1;
      step();
    end
  endtask

  initial begin
    rstm = 1; rst2 = 1;
    sel_valid = 0; coin_valid = 0; cancel = 0; sensor_t = 0; chg_ready = 0;
    sel_station = 0; sel_qty = 0; coin_val = 0;
    step(); step();
    chk("rst_state", int'(state), 0);
    rstm = 0;
    step();

    // Exact fare, single ticket to station 5.
    sel(5, 1);
    chk("a_state", int'(state), 2);
    chk("a_fare", int'(disp_val), 25);
    coin(20);
    chk("a_due", int'(disp_val), 5);
    coin(5);
    chk("a_disp", int'(state), 4);
    chk("a_nochg", int'(chg_valid), 0);
    take_tickets(1, 5);
    chk("a_clear", int'(state), 7);
    step();
    chk("a_idle", int'(state), 0);

    // Overpay, two tickets, change held until ready.
    sel(0, 2);
    chk("b_fare", int'(disp_val), 40);
    coin(50);
    chk("b_chg", int'(state), 3);
    chk("b_amt", int'(chg_amt), 10);
    step(); step();
    chk("b_hold_v", int'(chg_valid), 1);
    chk("b_hold_a", int'(chg_amt), 10);
    chg_ready = 1;
    step();
    chk("b_vlow", int'(chg_valid), 0);
    take_tickets(2, 0);
    chk("b_clear", int'(state), 7);
    step();

    // Cancel with a simultaneous coin.
    sel(3, 1);
    coin(10);
    chk("c_due", int'(disp_val), 5);
    coin_val = 5; coin_valid = 1; cancel = 1;
    step();
    chk("c_refund", int'(state), 6);
    chk("c_amt", int'(chg_amt), 15);
    chk("c_nopulse", int'(tkt_pulse), 0);
    chg_ready = 1;
    step();
    chk("c_clear", int'(state), 7);
    step();

    // Largest fare, overflowing coin rejected.
    sel(15, 3);
    chk("d_fare", int'(disp_val), 225);
    coin(200);
    coin(100);
    chk("d_rej", int'(coin_rej), 1);
    chk("d_due", int'(disp_val), 25);
    coin(25);
    chk("d_disp", int'(state), 4);
    take_tickets(3, 15);
    chk("d_clear", int'(state), 7);
    step();

    // Zero quantity and coin while idle.
    sel_station = 4; sel_qty = 0; sel_valid = 1;
    step();
    chk("e_err", int'(err), 1);
    chk("e_idle", int'(state), 0);
    step();
    chk("e_errlow", int'(err), 0);
    coin(7);
    chk("e_rej", int'(coin_rej), 1);

    // Out-of-range station and fare overflow on the 12-station instance.
    rst2 = 0;
    step();
    sel_station = 13; sel_qty = 1; sel_valid = 1;
    step();
    chk("f_range_err", int'(s_err), 1);
    chk("f_range_st", int'(s_state), 0);
    chk("f_main_calc", int'(state), 1);
    step();
    sel(11, 1);
    chk("f_ovf_err", int'(s_err), 1);
    chk("f_ovf_st", int'(s_state), 0);
    rst2 = 1;
    cancel = 1;
    step();
    chk("f_cancel", int'(state), 7);
    step();

    // Inactivity with a partial payment.
    sel(1, 1);
    coin(10);
`ifdef TICKET_TIMEOUT_EN
    repeat (99) step();
    chk("g_wait", int'(state), 2);
    step();
    chk("g_to", int'(state), 6);
    chk("g_amt", int'(chg_amt), 10);
`else
    repeat (1000) step();
    chk("g_wait", int'(state), 2);
    cancel = 1;
    step();
    chk("g_refund", int'(chg_amt), 10);
`endif
    chg_ready = 1;
    step();
    step();

    // Reset while change is being offered.
    sel(0, 1);
    coin(30);
    chk("h_chg", int'(chg_valid), 1);
    rstm = 1;
    #1;
    chk("h_v", int'(chg_valid), 0);
    chk("h_st", int'(state), 0);
    chk("h_amt", int'(chg_amt), 0);
    chk("h_disp", int'(disp_val), 0);
    step();
    rstm = 0;
    step();
    chk("h_idle", int'(state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
